// File: rtl/multi_dma.sv
// Multi-channel byte DMA: per-channel descriptors share one read/write engine with
// lowest-index arbitration; hblank-mode channels move BLOCK bytes per pacing pulse.
module multi_dma #(
  parameter int CHANNELS = 2,
  parameter int AW       = 16,
  parameter int LEN_W    = 8,
  parameter int BLOCK    = 16
) (
  input  logic                      clk1,
  input  logic                      nreset,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       abort,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS*AW-1:0]    src,
  input  logic [CHANNELS*AW-1:0]    dst,
  input  logic [CHANNELS*LEN_W-1:0] len,
  input  logic                      hblank,
  output logic                      rd_req,
  output logic [AW-1:0]             rd_a,
  input  logic                      rd_ack,
  input  logic [7:0]                rd_d,
  output logic                      wr_req,
  output logic [AW-1:0]             wr_a,
  output logic [7:0]                wr_d,
  input  logic                      wr_ack,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done,
  output logic                      stall
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BW = (BLOCK > 1) ? $clog2(BLOCK) : 1;
  localparam int RW = LEN_W + 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, HOLD} state_t;
  state_t state_q, state_d;

  logic [AW-1:0]       src_q [CHANNELS];
  logic [AW-1:0]       dst_q [CHANNELS];
  logic [RW-1:0]       rem_q [CHANNELS];
  logic [CHANNELS-1:0] mode_q, busy_q, credit_q, done_q;

  logic [CW-1:0] cur_q, grant_idx;
  logic [BW-1:0] blk_q;
  logic [7:0]    data_q;
  logic          kill_q;

  logic [CHANNELS-1:0] elig;
  logic grant, cur_abort, step, finish, blk_end;

  always_comb begin
    elig      = busy_q & (~mode_q | credit_q) & ~abort;
    grant     = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (elig[i] && !grant) begin
        grant     = 1'b1;
        grant_idx = CW'(i);
      end
    end
    cur_abort = abort[cur_q];
    state_d   = state_q;
    step      = 1'b0;
    finish    = 1'b0;
    blk_end   = 1'b0;
    case (state_q)
      IDLE:  if (grant) state_d = READ;
      READ: begin
        if (cur_abort)   state_d = IDLE;
        else if (rd_ack) state_d = WRITE;
      end
      WRITE: begin
        if (wr_ack) begin
          // An abort seen at any point during the write drops the byte's bookkeeping.
          if (kill_q || cur_abort) begin
            state_d = IDLE;
          end else begin
            step = 1'b1;
            if (rem_q[cur_q] == RW'(1)) begin
              finish  = 1'b1;
              state_d = IDLE;
            end else if (mode_q[cur_q] && blk_q == BW'(BLOCK - 1)) begin
              blk_end = 1'b1;
              state_d = HOLD;
            end else begin
              state_d = READ;
            end
          end
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      blk_q   <= '0;
      data_q  <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= (state_d == WRITE) && (kill_q || cur_abort);
      if (state_q == IDLE && grant) begin
        cur_q <= grant_idx;
        blk_q <= '0;
      end else if (step) begin
        blk_q <= blk_q + BW'(1);
      end
      if (state_q == READ && rd_ack) data_q <= rd_d;
    end
  end

  always_ff @(posedge clk1 or negedge nreset) begin
    if (!nreset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        src_q[i] <= '0;
        dst_q[i] <= '0;
        rem_q[i] <= '0;
      end
      mode_q   <= '0;
      busy_q   <= '0;
      credit_q <= '0;
      done_q   <= '0;
    end else begin
      done_q <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (abort[i]) begin
          busy_q[i]   <= 1'b0;
          credit_q[i] <= 1'b0;
        end else if (start[i] && !busy_q[i]) begin
          busy_q[i]   <= 1'b1;
          credit_q[i] <= 1'b0;
          mode_q[i]   <= mode[i];
          src_q[i]    <= src[i*AW +: AW];
          dst_q[i]    <= dst[i*AW +: AW];
          rem_q[i]    <= RW'(len[i*LEN_W +: LEN_W]) + RW'(1);
        end else begin
          if (step && cur_q == CW'(i)) begin
            src_q[i] <= src_q[i] + AW'(1);
            dst_q[i] <= dst_q[i] + AW'(1);
            rem_q[i] <= rem_q[i] - RW'(1);
          end
          // Consuming a credit takes priority over a coincident hblank pulse.
          if (finish && cur_q == CW'(i)) begin
            busy_q[i]   <= 1'b0;
            credit_q[i] <= 1'b0;
            done_q[i]   <= 1'b1;
          end else if (blk_end && cur_q == CW'(i)) begin
            credit_q[i] <= 1'b0;
          end else if (hblank && busy_q[i] && mode_q[i]) begin
            credit_q[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign rd_req = (state_q == READ);
  assign wr_req = (state_q == WRITE);
  assign rd_a   = rd_req ? src_q[cur_q] : '0;
  assign wr_a   = wr_req ? dst_q[cur_q] : '0;
  assign wr_d   = wr_req ? data_q : '0;
  assign stall  = rd_req | wr_req;
  assign busy   = busy_q;
  assign done   = done_q;
endmodule

// File: tb/tb_multi_dma.sv
// Randomised self-checking bench for multi_dma: bus responders with variable wait
// states, a byte-level transfer model and a log of observed reads/writes/dones.
module tb_multi_dma;
  localparam int CH  = 2;
  localparam int AW  = 16;
  localparam int LW  = 8;
  localparam int BLK = 16;

  logic clk1 = 1'b0;
  logic nreset;
  logic [CH-1:0]    start, abort, mode;
  logic [CH*AW-1:0] src, dst;
  logic [CH*LW-1:0] len;
  logic hblank, rd_req, rd_ack, wr_req, wr_ack, stall;
  logic [AW-1:0] rd_a, wr_a;
  logic [7:0] rd_d, wr_d;
  logic [CH-1:0] busy, done;

  multi_dma #(.CHANNELS(CH), .AW(AW), .LEN_W(LW), .BLOCK(BLK)) dut (
    .clk1(clk1), .nreset(nreset), .start(start), .abort(abort), .mode(mode),
    .src(src), .dst(dst), .len(len), .hblank(hblank),
    .rd_req(rd_req), .rd_a(rd_a), .rd_ack(rd_ack), .rd_d(rd_d),
    .wr_req(wr_req), .wr_a(wr_a), .wr_d(wr_d), .wr_ack(wr_ack),
    .busy(busy), .done(done), .stall(stall)
  );

  initial forever #5 clk1 = ~clk1;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  logic [7:0]  mem [65536];
  wr_t         wlog[$];
  wr_t         exp_q[$];
  logic [15:0] rlog[$];
  int done_cnt[CH];
  int done_cyc[CH];
  int cyc = 0;
  int rd_lo = 0, rd_hi = 0, wr_lo = 0, wr_hi = 0;
  int rd_wait = 0, wr_wait = 0;
  bit rd_in = 0, wr_in = 0;
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Memory slave and observer, all on the falling edge.
  always @(negedge clk1) begin
    cyc++;
    for (int c = 0; c < CH; c++)
      if (done[c]) begin
        done_cnt[c]++;
        done_cyc[c] = cyc;
      end
    if (rd_req) begin
      if (!rd_in) begin
        rd_in   = 1;
        rd_wait = $urandom_range(rd_hi, rd_lo);
      end
      if (rd_wait == 0) begin
        rd_ack = 1;
        rd_d   = mem[rd_a];
        rlog.push_back(rd_a);
        rd_in  = 0;
      end else begin
        rd_ack = 0;
        rd_wait--;
      end
    end else begin
      rd_ack = 0;
      rd_in  = 0;
    end
    if (wr_req) begin
      if (!wr_in) begin
        wr_in   = 1;
        wr_wait = $urandom_range(wr_hi, wr_lo);
      end
      if (wr_wait == 0) begin
        wr_ack = 1;
        wlog.push_back('{a: wr_a, d: wr_d});
        wr_in  = 0;
      end else begin
        wr_ack = 0;
        wr_wait--;
      end
    end else begin
      wr_ack = 0;
      wr_in  = 0;
    end
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic set_ch(input int ch, input bit m, input logic [15:0] s,
                        input logic [15:0] d, input int l);
    mode[ch]          = m;
    src[ch*AW +: AW]  = s;
    dst[ch*AW +: AW]  = d;
    len[ch*LW +: LW]  = LW'(l);
  endtask

  task automatic pulse_start(input logic [CH-1:0] m);
    start = m;
    tick();
    start = '0;
  endtask

  task automatic pulse_hblank();
    hblank = 1;
    tick();
    hblank = 0;
  endtask

  task automatic clr_done();
    for (int c = 0; c < CH; c++) begin
      done_cnt[c] = 0;
      done_cyc[c] = 0;
    end
  endtask

  // Expected write stream for one whole transfer: byte k goes from src+k to dst+k.
  task automatic push_xfer(input logic [15:0] s, input logic [15:0] d, input int l);
    logic [15:0] sa, da;
    sa = s;
    da = d;
    for (int k = 0; k <= l; k++) begin
      exp_q.push_back('{a: da, d: mem[sa]});
      sa++;
      da++;
    end
  endtask

  task automatic cmp_writes(input string tag);
    bit bad = 0;
    chk({tag, "_count"}, wlog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wlog.size() && !bad; i++) begin
      chk({tag, "_addr_data"}, wlog[i], exp_q[i]);
      bad = (wlog[i] !== exp_q[i]);
    end
    wlog.delete();
    exp_q.delete();
  endtask

  task automatic wait_done(input int ch, input int target, input int budget, input string tag);
    int n = 0;
    while (done_cnt[ch] < target && n < budget) begin
      tick();
      n++;
    end
    chk(tag, done_cnt[ch], target);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy != '0 || stall) && n < 2000) begin
      tick();
      n++;
    end
    chk(tag, {busy, stall}, 0);
  endtask

  task automatic set_delays(input int rl, input int rh, input int wl, input int wh);
    rd_lo = rl; rd_hi = rh; wr_lo = wl; wr_hi = wh;
  endtask

  initial begin
    int n, nr, act[CH];
    logic [15:0] ea, rs[CH], rdst[CH];
    int rl[CH];
    bit all_long;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    nreset = 0; start = '0; abort = '0; mode = '0; src = '0; dst = '0; len = '0;
    hblank = 0; rd_ack = 0; wr_ack = 0; rd_d = '0;
    clr_done();
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", {rd_req, wr_req, stall}, 0);
    chk("rst_addr", {rd_a, wr_a, wr_d}, 0);
    nreset = 1;
    tick();

    // Long general transfer, zero-wait bus.
    set_delays(0, 0, 0, 0);
    set_ch(0, 0, 16'hC000, 16'hFE00, 159);
    pulse_start(2'b01);
    push_xfer(16'hC000, 16'hFE00, 159);
    wait_done(0, 1, 2000, "gen_done");
    repeat (5) tick();
    chk("gen_done_once", done_cnt[0], 1);
    chk("gen_stall_after", stall, 0);
    chk("gen_busy_after", busy, 0);
    cmp_writes("gen_writes");

    // Two general channels started together: channel 0 fully first.
    clr_done();
    set_delays(0, 2, 0, 2);
    set_ch(0, 0, 16'h1000, 16'h2000, 3);
    set_ch(1, 0, 16'h3000, 16'h4000, 3);
    pulse_start(2'b11);
    push_xfer(16'h1000, 16'h2000, 3);
    push_xfer(16'h3000, 16'h4000, 3);
    wait_done(1, 1, 500, "pri_done1");
    chk("pri_done0", done_cnt[0], 1);
    chk("pri_order", done_cyc[0] < done_cyc[1], 1);
    cmp_writes("pri_writes");

    // Source address wrap.
    clr_done();
    rlog.delete();
    set_ch(0, 0, 16'hFFFE, 16'h5000, 3);
    pulse_start(2'b01);
    push_xfer(16'hFFFE, 16'h5000, 3);
    wait_done(0, 1, 500, "wrap_done");
    chk("wrap_reads", rlog.size(), 4);
    ea = 16'hFFFE;
    for (int k = 0; k < 4 && k < rlog.size(); k++) begin
      chk("wrap_rd_a", rlog[k], ea);
      ea++;
    end
    cmp_writes("wrap_writes");

    // Hblank pacing on channel 1.
    clr_done();
    set_delays(0, 1, 0, 1);
    set_ch(1, 1, 16'h8000, 16'h9000, 31);
    pulse_start(2'b10);
    repeat (10) tick();
    chk("hb_wait_nocredit", wlog.size(), 0);
    chk("hb_busy", busy, 2'b10);
    pulse_hblank();
    n = 0;
    while (wlog.size() < 16 && n < 300) begin tick(); n++; end
    repeat (10) tick();
    chk("hb_block1", wlog.size(), 16);
    chk("hb_stall_gap", stall, 0);
    chk("hb_nodone_yet", done_cnt[1], 0);
    pulse_hblank();
    wait_done(1, 1, 300, "hb_done");
    chk("hb_block2", wlog.size(), 32);
    pulse_hblank();
    repeat (20) tick();
    chk("hb_third_ignored", wlog.size(), 32);
    chk("hb_busy_end", busy, 0);
    chk("hb_done_once", done_cnt[1], 1);
    push_xfer(16'h8000, 16'h9000, 31);
    cmp_writes("hb_writes");

    // Abort while a slow write is outstanding.
    clr_done();
    rlog.delete();
    set_delays(0, 0, 3, 3);
    set_ch(0, 0, 16'h2000, 16'h6000, 7);
    pulse_start(2'b01);
    n = 0;
    while (!(wr_req && wlog.size() >= 2) && n < 200) begin tick(); n++; end
    chk("abt_reach_write", wr_req, 1);
    n  = wlog.size();
    nr = rlog.size();
    abort = 2'b01;
    tick();
    abort = '0;
    repeat (20) tick();
    chk("abt_write_done", wlog.size(), n + 1);
    chk("abt_no_reads", rlog.size(), nr);
    chk("abt_busy", busy, 0);
    chk("abt_no_done", done_cnt[0], 0);
    chk("abt_stall", stall, 0);
    push_xfer(16'h2000, 16'h6000, n);
    cmp_writes("abt_writes");

    // Asynchronous reset in the middle of a read.
    clr_done();
    set_delays(5, 5, 0, 0);
    set_ch(0, 0, 16'h3000, 16'h7000, 5);
    pulse_start(2'b01);
    n = 0;
    while (!rd_req && n < 50) begin tick(); n++; end
    chk("rst_mid_reach_read", rd_req, 1);
    nreset = 0;
    #1;
    chk("rst_mid_rdreq", rd_req, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_stall", stall, 0);
    repeat (2) tick();
    nreset = 1;
    repeat (5) tick();
    chk("rst_mid_nodone", done_cnt[0], 0);
    wlog.delete();
    rlog.delete();
    set_delays(0, 2, 0, 2);
    set_ch(0, 0, 16'h3100, 16'h7100, 0);
    pulse_start(2'b01);
    push_xfer(16'h3100, 16'h7100, 0);
    wait_done(0, 1, 100, "rst_single_done");
    repeat (3) tick();
    chk("rst_single_once", done_cnt[0], 1);
    cmp_writes("rst_single_writes");

    // Random general-mode traffic, including start/abort collisions and
    // redundant starts on armed channels.
    for (int it = 0; it < 25; it++) begin
      clr_done();
      set_delays(0, $urandom_range(2, 0), 0, $urandom_range(2, 0));
      all_long = 1;
      for (int c = 0; c < CH; c++) begin
        act[c]  = $urandom_range(2, 0);
        rs[c]   = 16'($urandom);
        rdst[c] = 16'($urandom);
        rl[c]   = $urandom_range(24, 2);
        set_ch(c, 0, rs[c], rdst[c], rl[c]);
      end
      if (act[0] == 0 && act[1] == 0) act[0] = 1;
      for (int c = 0; c < CH; c++) begin
        start[c] = (act[c] != 0);
        abort[c] = (act[c] == 2);
      end
      tick();
      start = '0;
      abort = '0;
      for (int c = 0; c < CH; c++) begin
        if (act[c] == 1) push_xfer(rs[c], rdst[c], rl[c]);
        chk("rnd_armed", busy[c], act[c] == 1);
      end
      tick();
      for (int c = 0; c < CH; c++)
        set_ch(c, 0, 16'($urandom), 16'($urandom), $urandom_range(24, 0));
      for (int c = 0; c < CH; c++) start[c] = (act[c] == 1);
      tick();
      start = '0;
      for (int c = 0; c < CH; c++)
        if (act[c] == 1) wait_done(c, 1, 1000, "rnd_done");
      wait_idle("rnd_idle");
      repeat (2) tick();
      for (int c = 0; c < CH; c++) chk("rnd_done_count", done_cnt[c], act[c] == 1);
      cmp_writes("rnd_writes");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1);
  end
endmodule
